core_frontend_ctrl: RTL and testbench

CORE_FRONTEND_CTRL -- requirements
Module: core_frontend_ctrl

---
 rtl/core_frontend_ctrl_pkg.sv | 37 +++
 rtl/core_cacop_fsm.sv | 81 ++++++++
 rtl/core_frontend_ctrl.sv | 128 ++++++++++++
 tb/tb_core_frontend_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_frontend_ctrl_pkg.sv
// rtl/core_frontend_ctrl_pkg.sv - shared frontend-control types, op codes and FSM states
package core_frontend_ctrl_pkg;

   // icache maintenance op codes carried on cacop_i / icache_op_o
   typedef enum logic [1:0] {
      CACOP_IDX_INIT = 2'd0,
      CACOP_IDX_INV  = 2'd1,
      CACOP_HIT_INV  = 2'd2,
      CACOP_RSVD     = 2'd3
   } cacop_op_e;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_SEND = 2'd1,
      C_WAIT = 2'd2,
      C_DONE = 2'd3
   } cacop_state_e;

   typedef enum logic {
      I_RUN  = 1'b0,
      I_WAIT = 1'b1
   } idle_state_e;

   typedef struct packed {
      logic        valid;
      logic        taken;
      logic [1:0]  br_type;
      logic [31:0] pc;
      logic [31:0] target;
   } bpu_correct_t;

   typedef struct packed {
      logic        rst_jmp;
      logic [31:0] target;
   } frontend_resp_t;

endpackage

// File: rtl/core_cacop_fsm.sv
// rtl/core_cacop_fsm.sv - icache-op handshake sequencer (send, min wait, ready, done)
module core_cacop_fsm
   import core_frontend_ctrl_pkg::*;
#(
   parameter int CACOP_MIN_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cacop_valid_i,
   input  logic [1:0]  cacop_i,
   input  logic [31:0] cacop_addr_i,
   input  logic        icache_ready_i,
   output logic        icache_op_valid_o,
   output logic [1:0]  icache_op_o,
   output logic [31:0] icacheop_addr_o,
   output logic        cacop_done_o,
   output logic        cmt_stall_o
);

   localparam int CW = (CACOP_MIN_WAIT < 2) ? 1 : $clog2(CACOP_MIN_WAIT + 1);
   localparam logic [CW-1:0] MIN_CNT = CW'(CACOP_MIN_WAIT);

   cacop_state_e r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_op_valid;
   logic          r_done;
   logic [1:0]    r_op;
   logic [31:0]   r_addr;

   // sequence one op; ready is only trusted once the minimum wait has elapsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= C_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_op_valid <= 1'b0;
         r_done     <= 1'b0;
         r_op       <= 2'd0;
         r_addr     <= 32'd0;
      end else begin
         r_op_valid <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            C_IDLE: begin
               if (cacop_valid_i) begin
                  r_state    <= C_SEND;
                  r_op       <= cacop_i;
                  r_addr     <= cacop_addr_i;
                  r_op_valid <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            C_SEND: begin
               r_state <= C_WAIT;
               r_cnt   <= '0;
            end
            C_WAIT: begin
               if (r_cnt < MIN_CNT) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (icache_ready_i) begin
                  r_state <= C_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= C_IDLE;
            end
         endcase
      end
   end

   // commit must already hold in the cycle the request is taken
   assign cmt_stall_o       = r_busy | ((r_state == C_IDLE) & cacop_valid_i);
   assign icache_op_valid_o = r_op_valid;
   assign icache_op_o       = r_op;
   assign icacheop_addr_o   = r_addr;
   assign cacop_done_o      = r_done;

endmodule

// File: rtl/core_frontend_ctrl.sv
// rtl/core_frontend_ctrl.sv - frontend redirect, BPU training, idle lock and icache-op control
module core_frontend_ctrl
   import core_frontend_ctrl_pkg::*;
#(
   parameter int CACOP_MIN_WAIT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmt_redirect_i,
   input  logic [31:0]  cmt_target_i,
   input  logic         ex_mispred_i,
   input  logic [31:0]  ex_target_i,
   input  bpu_correct_t ex_correct_i,
   input  logic         cacop_valid_i,
   input  logic [1:0]   cacop_i,
   input  logic [31:0]  cacop_addr_i,
   output logic         cacop_done_o,
   input  logic         idle_i,
   input  logic         int_pending_i,
   input  logic         icache_ready_i,
   output logic         rst_jmp_o,
   output logic [31:0]  rst_jmp_target_o,
   output bpu_correct_t bpu_correct_o,
   output logic         icache_op_valid_o,
   output logic [1:0]   icache_op_o,
   output logic [31:0]  icacheop_addr_o,
   output logic         wait_inst_o,
   output logic         int_detect_o,
   output logic         cmt_stall_o
);

   frontend_resp_t r_resp;
   logic           r_cmt_d;
   bpu_correct_t   r_bpu;
   idle_state_e    r_istate;
   logic           r_wait;
   logic           r_int;
   logic           w_ex_take;

   // an EX mispredict right after a commit redirect belongs to a flushed instruction
   assign w_ex_take = ex_mispred_i & ~cmt_redirect_i & ~r_cmt_d;

   // redirect pulse and target, commit wins over EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp  <= '0;
         r_cmt_d <= 1'b0;
      end else begin
         r_cmt_d <= cmt_redirect_i;
         if (cmt_redirect_i) begin
            r_resp.rst_jmp <= 1'b1;
            r_resp.target  <= cmt_target_i;
         end else if (w_ex_take) begin
            r_resp.rst_jmp <= 1'b1;
            r_resp.target  <= ex_target_i;
         end else begin
            r_resp.rst_jmp <= 1'b0;
         end
      end
   end

   // training info follows any mispredict not overridden by commit; otherwise invalidated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bpu <= '0;
      end else if (ex_mispred_i && !cmt_redirect_i) begin
         r_bpu <= ex_correct_i;
      end else begin
         r_bpu.valid <= 1'b0;
      end
   end

   // idle lock: sleep until an interrupt or a commit redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_istate <= I_RUN;
         r_wait   <= 1'b0;
         r_int    <= 1'b0;
      end else begin
         r_int <= 1'b0;
         case (r_istate)
            I_RUN: begin
               if (idle_i) begin
                  if (int_pending_i) begin
                     r_int <= 1'b1;
                  end else begin
                     r_istate <= I_WAIT;
                     r_wait   <= 1'b1;
                  end
               end
            end
            default: begin
               if (int_pending_i) begin
                  r_istate <= I_RUN;
                  r_wait   <= 1'b0;
                  r_int    <= 1'b1;
               end else if (cmt_redirect_i) begin
                  r_istate <= I_RUN;
                  r_wait   <= 1'b0;
               end
            end
         endcase
      end
   end

   core_cacop_fsm #(
      .CACOP_MIN_WAIT(CACOP_MIN_WAIT)
   ) u_cacop (
      .clk               (clk),
      .rst_n             (rst_n),
      .cacop_valid_i     (cacop_valid_i),
      .cacop_i           (cacop_i),
      .cacop_addr_i      (cacop_addr_i),
      .icache_ready_i    (icache_ready_i),
      .icache_op_valid_o (icache_op_valid_o),
      .icache_op_o       (icache_op_o),
      .icacheop_addr_o   (icacheop_addr_o),
      .cacop_done_o      (cacop_done_o),
      .cmt_stall_o       (cmt_stall_o)
   );

   assign rst_jmp_o        = r_resp.rst_jmp;
   assign rst_jmp_target_o = r_resp.target;
   assign bpu_correct_o    = r_bpu;
   assign wait_inst_o      = r_wait;
   assign int_detect_o     = r_int;

endmodule

// File: tb/tb_core_frontend_ctrl.sv
// tb/tb_core_frontend_ctrl.sv - self-checking bench for core_frontend_ctrl
module tb_core_frontend_ctrl;
   import core_frontend_ctrl_pkg::*;

   localparam int MIN_WAIT = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmt_redirect_i, ex_mispred_i, cacop_valid_i, idle_i, int_pending_i, icache_ready_i;
   logic [31:0]  cmt_target_i, ex_target_i, cacop_addr_i;
   bpu_correct_t ex_correct_i;
   logic [1:0]   cacop_i;
   logic         cacop_done_o, rst_jmp_o, icache_op_valid_o, wait_inst_o, int_detect_o, cmt_stall_o;
   logic [31:0]  rst_jmp_target_o, icacheop_addr_o;
   bpu_correct_t bpu_correct_o;
   logic [1:0]   icache_op_o;

   always #5 clk = ~clk;

   core_frontend_ctrl #(.CACOP_MIN_WAIT(MIN_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmt_redirect_i(cmt_redirect_i), .cmt_target_i(cmt_target_i),
      .ex_mispred_i(ex_mispred_i), .ex_target_i(ex_target_i), .ex_correct_i(ex_correct_i),
      .cacop_valid_i(cacop_valid_i), .cacop_i(cacop_i), .cacop_addr_i(cacop_addr_i),
      .cacop_done_o(cacop_done_o), .idle_i(idle_i), .int_pending_i(int_pending_i),
      .icache_ready_i(icache_ready_i), .rst_jmp_o(rst_jmp_o), .rst_jmp_target_o(rst_jmp_target_o),
      .bpu_correct_o(bpu_correct_o), .icache_op_valid_o(icache_op_valid_o),
      .icache_op_o(icache_op_o), .icacheop_addr_o(icacheop_addr_o),
      .wait_inst_o(wait_inst_o), .int_detect_o(int_detect_o), .cmt_stall_o(cmt_stall_o)
   );

   typedef struct packed {
      logic         cmt;
      logic [31:0]  cmt_t;
      logic         ex;
      logic [31:0]  ex_t;
      bpu_correct_t corr;
      logic         cv;
      logic [1:0]   op;
      logic [31:0]  addr;
      logic         idle;
      logic         pend;
      logic         ready;
   } stim_t;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   stim_t        cur;
   int           cyc;
   logic         m_jmp, m_prev_cmt, m_sleep, m_int, m_act;
   logic [31:0]  m_tgt, m_addr;
   bpu_correct_t m_bpu;
   int           m_acc, m_done;
   logic [1:0]   m_op;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic can_acc(input int c);
      return !m_act || (m_done >= 0 && c > m_done);
   endfunction

   task automatic model_reset();
      cyc = 0; m_jmp = 0; m_prev_cmt = 0; m_sleep = 0; m_int = 0; m_act = 0;
      m_tgt = 0; m_addr = 0; m_bpu = '0; m_acc = 0; m_done = -1; m_op = 0;
   endtask

   task automatic apply(input stim_t s);
      cur = s;
      cmt_redirect_i = s.cmt;  cmt_target_i = s.cmt_t;
      ex_mispred_i   = s.ex;   ex_target_i  = s.ex_t;  ex_correct_i = s.corr;
      cacop_valid_i  = s.cv;   cacop_i      = s.op;    cacop_addr_i = s.addr;
      idle_i         = s.idle; int_pending_i = s.pend; icache_ready_i = s.ready;
   endtask

   // consume the inputs of cycle cyc and form expectations for cycle cyc+1
   task automatic model_advance();
      int   c;
      logic acc_now;
      c = cyc;
      acc_now = cur.cv && can_acc(c);
      if (cur.cmt) begin
         m_jmp = 1; m_tgt = cur.cmt_t;
      end else if (cur.ex && !m_prev_cmt) begin
         m_jmp = 1; m_tgt = cur.ex_t;
      end else begin
         m_jmp = 0;
      end
      m_prev_cmt = cur.cmt;
      if (cur.ex && !cur.cmt) m_bpu = cur.corr;
      else m_bpu.valid = 1'b0;
      m_int = 0;
      if (!m_sleep) begin
         if (cur.idle) begin
            if (cur.pend) m_int = 1;
            else m_sleep = 1;
         end
      end else if (cur.pend) begin
         m_sleep = 0; m_int = 1;
      end else if (cur.cmt) begin
         m_sleep = 0;
      end
      // op sent at acc+1, ready trusted from acc+2+MIN_WAIT, done the cycle after ready seen
      if (m_act && m_done < 0 && c >= m_acc + 2 + MIN_WAIT && cur.ready) m_done = c + 1;
      if (m_act && m_done >= 0 && c >= m_done) m_act = 0;
      if (acc_now) begin
         m_act = 1; m_acc = c; m_done = -1; m_op = cur.op; m_addr = cur.addr;
      end
      cyc = c + 1;
   endtask

   task automatic check_all();
      logic e_opv, e_done, e_stall;
      e_opv   = m_act && (cyc == m_acc + 1);
      e_done  = m_act && (m_done >= 0) && (cyc == m_done);
      e_stall = (cur.cv && can_acc(cyc)) ||
                (m_act && cyc > m_acc && (m_done < 0 || cyc < m_done));
      chk("rst_jmp", rst_jmp_o, m_jmp);
      if (m_jmp) chk("jmp_target", rst_jmp_target_o, m_tgt);
      chk("bpu_correct", bpu_correct_o, m_bpu);
      chk("wait_inst", wait_inst_o, m_sleep);
      chk("int_detect", int_detect_o, m_int);
      chk("op_valid", icache_op_valid_o, e_opv);
      if (e_opv) begin
         chk("op_code", icache_op_o, m_op);
         chk("op_addr", icacheop_addr_o, m_addr);
      end
      chk("cacop_done", cacop_done_o, e_done);
      chk("cmt_stall", cmt_stall_o, e_stall);
   endtask

   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      model_advance();
      apply(s);
      @(negedge clk);
      check_all();
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.cmt   = ($urandom_range(7) == 0);
      s.cmt_t = $urandom;
      s.ex    = ($urandom_range(3) == 0);
      s.ex_t  = $urandom;
      s.corr  = {$urandom, $urandom, $urandom};
      s.cv    = ($urandom_range(5) == 0);
      s.op    = 2'($urandom);
      s.addr  = $urandom;
      s.idle  = ($urandom_range(9) == 0);
      s.pend  = ($urandom_range(11) == 0);
      s.ready = ($urandom_range(2) == 0);
      return s;
   endfunction

   task automatic drain();
      stim_t s;
      s = '0; s.ready = 1; s.pend = 1;
      step(s);
      s.pend = 0;
      repeat (12) step(s);
   endtask

   initial begin
      stim_t s, z;
      bpu_correct_t bc;
      int opv_cnt, wcnt, icnt, dcnt;
      z = '0;
      apply(z);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rst_jmp", rst_jmp_o, 0);
      chk("reset_target", rst_jmp_target_o, 0);
      chk("reset_bpu", bpu_correct_o, 0);
      chk("reset_opv", icache_op_valid_o, 0);
      chk("reset_done", cacop_done_o, 0);
      chk("reset_wait", wait_inst_o, 0);
      chk("reset_int", int_detect_o, 0);
      chk("reset_stall", cmt_stall_o, 0);
      @(negedge clk);
      rst_n = 1;
      step(z);

      // commit and EX redirect in the same cycle
      bc = '{valid: 1'b1, taken: 1'b1, br_type: 2'd1, pc: 32'h1C0001F0, target: 32'h1C000200};
      s = z; s.cmt = 1; s.cmt_t = 32'h1C000100; s.ex = 1; s.ex_t = 32'h1C000200; s.corr = bc;
      step(s);
      step(z);
      chk("prio_jmp", rst_jmp_o, 1);
      chk("prio_target", rst_jmp_target_o, 32'h1C000100);
      chk("prio_bpu_valid", bpu_correct_o.valid, 0);
      step(z);
      chk("prio_single_pulse", rst_jmp_o, 0);

      // plain EX mispredict
      bc = '{valid: 1'b1, taken: 1'b0, br_type: 2'd2, pc: 32'h1C000030, target: 32'h1C000040};
      s = z; s.ex = 1; s.ex_t = 32'h1C000040; s.corr = bc;
      step(s);
      chk("mis_no_comb_jmp", rst_jmp_o, 0);
      step(z);
      chk("mis_jmp", rst_jmp_o, 1);
      chk("mis_target", rst_jmp_target_o, 32'h1C000040);
      chk("mis_bpu", bpu_correct_o, bc);
      step(z);
      chk("mis_single_pulse", rst_jmp_o, 0);

      // icache op with ready held low for five cycles
      drain();
      s = z; s.cv = 1; s.op = 2'd2; s.addr = 32'h80001000;
      step(s);
      chk("cacop_stall_accept", cmt_stall_o, 1);
      opv_cnt = 0;
      for (int i = 1; i <= 4; i++) begin
         step(z);
         opv_cnt += int'(icache_op_valid_o);
         chk("cacop_stall_wait", cmt_stall_o, 1);
         if (i == 1) begin
            chk("cacop_op", icache_op_o, 2'd2);
            chk("cacop_addr", icacheop_addr_o, 32'h80001000);
         end
      end
      s = z; s.ready = 1;
      step(s);
      chk("cacop_stall_ready", cmt_stall_o, 1);
      chk("cacop_done_early", cacop_done_o, 0);
      step(z);
      chk("cacop_done", cacop_done_o, 1);
      chk("cacop_stall_done", cmt_stall_o, 0);
      step(z);
      chk("cacop_done_single", cacop_done_o, 0);
      chk("cacop_opv_count", opv_cnt, 1);

      // idle then interrupt ten cycles later
      drain();
      s = z; s.idle = 1;
      step(s);
      wcnt = 0; icnt = 0;
      for (int i = 0; i < 12; i++) begin
         s = z;
         if (i == 9) s.pend = 1;
         step(s);
         wcnt += int'(wait_inst_o);
         icnt += int'(int_detect_o);
      end
      chk("idle_wait_cycles", wcnt, 10);
      chk("idle_int_pulses", icnt, 1);
      chk("idle_back_run", wait_inst_o, 0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) step(rand_stim());

      // reset while waiting for icache ready
      drain();
      s = z; s.cv = 1; s.op = 2'd1; s.addr = 32'h00000ABC;
      step(s);
      repeat (3) step(z);
      #2;
      rst_n = 0;
      #1;
      chk("rst_mid_jmp", rst_jmp_o, 0);
      chk("rst_mid_target", rst_jmp_target_o, 0);
      chk("rst_mid_bpu", bpu_correct_o, 0);
      chk("rst_mid_opv", icache_op_valid_o, 0);
      chk("rst_mid_done", cacop_done_o, 0);
      chk("rst_mid_wait", wait_inst_o, 0);
      chk("rst_mid_int", int_detect_o, 0);
      chk("rst_mid_stall", cmt_stall_o, 0);
      model_reset();
      apply(z);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      dcnt = 0;
      s = z; s.ready = 1;
      for (int i = 0; i < 8; i++) begin
         step(s);
         dcnt += int'(cacop_done_o);
      end
      chk("rst_no_done", dcnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
